// File: rtl/cpu_defs.sv
// Shared CPU constants: register width, index width and named register indices.
// The control unit and dest-select mux use these same values.
package cpu_defs;

  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = 1 << REG_ADDR_W;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/regfile32.sv
// 32 x 32 register file: two combinational read ports plus a debug read port,
// one synchronous write port, r0 hardwired to zero, r29 resets to SP_RESET.
module regfile32
  import cpu_defs::*;
#(
  parameter int               DATA_W   = REG_W,
  parameter int               ADDR_W   = REG_ADDR_W,
  parameter logic [DATA_W-1:0] SP_RESET = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] dbg_a,
  output logic [DATA_W-1:0] dbg_d
);

  localparam int NREG = 1 << ADDR_W;

  typedef logic [NREG-1:1][DATA_W-1:0] regarr_t;

  // r0 has no storage; the array starts at index 1.
  regarr_t regs;

  for (genvar i = 1; i < NREG; i++) begin : g_reg
    logic wr_hit;
    assign wr_hit = we && (wa == ADDR_W'(i));

    always_ff @(posedge clk) begin
      if (!rst_n)
        regs[i] <= (ADDR_W'(i) == ADDR_W'(REG_SP)) ? SP_RESET : '0;
      else if (wr_hit)
        regs[i] <= wd;
    end
  end

  // No write-to-read bypass: a same-cycle write would close a loop through
  // the ALU and write-back mux, so reads always see pre-edge contents.
  function automatic logic [DATA_W-1:0] rsel(input regarr_t r,
                                             input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int i = 1; i < NREG; i++)
      if (a == ADDR_W'(i)) d = r[i];
    return d;
  endfunction

  assign rd1   = rsel(regs, ra1);
  assign rd2   = rsel(regs, ra2);
  assign dbg_d = rsel(regs, dbg_a);

endmodule

// File: tb/tb_regfile32.sv
// Directed bench for regfile32: vector table plus hand-written reset and
// same-cycle read/write sequences.
module tb_regfile32;

  localparam logic [31:0] SPR = 32'h0000_3FFC;

  logic        clk, rst_n, we;
  logic [4:0]  ra1, ra2, wa, dbg_a;
  logic [31:0] rd1, rd2, wd, dbg_d;

  regfile32 #(.DATA_W(32), .ADDR_W(5), .SP_RESET(SPR)) dut (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we(we), .wa(wa), .wd(wd), .dbg_a(dbg_a), .dbg_d(dbg_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1, ra2, dbg_a;
    logic [31:0] e1, e2, ed;
  } vec_t;

  vec_t        vt[7];
  logic [31:0] shadow[32];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input string n);
    for (int a = 0; a < 32; a++) begin
      dbg_a = 5'(a);
      #1;
      chk($sformatf("%s r%0d", n, a), dbg_d, shadow[a]);
    end
  endtask

  initial begin
    vt[0] = '{1'b1, 5'd8,  32'h1234_5678, 5'd8,  5'd0,  5'd5,  32'h1234_5678, 32'h0, 32'h0};
    vt[1] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 5'd8,  5'd31, 5'd29, 32'h1234_5678, 32'hFFFF_FFFF, SPR};
    vt[2] = '{1'b1, 5'd0,  32'hAAAA_AAAA, 5'd0,  5'd0,  5'd0,  32'h0, 32'h0, 32'h0};
    vt[3] = '{1'b1, 5'd3,  32'h0000_0001, 5'd3,  5'd8,  5'd31, 32'h1, 32'h1234_5678, 32'hFFFF_FFFF};
    vt[4] = '{1'b1, 5'd10, 32'h0000_0055, 5'd10, 5'd3,  5'd10, 32'h55, 32'h1, 32'h55};
    vt[5] = '{1'b0, 5'd10, 32'h0000_0099, 5'd10, 5'd10, 5'd10, 32'h55, 32'h55, 32'h55};
    vt[6] = '{1'b1, 5'd29, 32'h0000_1000, 5'd29, 5'd31, 5'd29, 32'h1000, 32'hFFFF_FFFF, 32'h1000};

    // Reset edge with a concurrent write that must be discarded.
    rst_n = 1'b0; we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF;
    ra1 = 5'd5; ra2 = 5'd29; dbg_a = 5'd0;
    edge_step();
    rst_n = 1'b1; we = 1'b0;
    for (int a = 0; a < 32; a++) shadow[a] = (a == 29) ? SPR : 32'h0;
    chk("reset rd1 r5", rd1, 32'h0);
    chk("reset rd2 r29", rd2, SPR);
    sweep("reset");

    // Table vectors: one write edge each, reads checked after the edge.
    for (int i = 0; i < 7; i++) begin
      we = vt[i].we; wa = vt[i].wa; wd = vt[i].wd;
      ra1 = vt[i].ra1; ra2 = vt[i].ra2; dbg_a = vt[i].dbg_a;
      edge_step();
      if (vt[i].we && vt[i].wa != 5'd0) shadow[vt[i].wa] = vt[i].wd;
      chk($sformatf("vec%0d rd1", i), rd1, vt[i].e1);
      chk($sformatf("vec%0d rd2", i), rd2, vt[i].e2);
      chk($sformatf("vec%0d dbg", i), dbg_d, vt[i].ed);
    end
    we = 1'b0;
    sweep("post-table");

    // Same-cycle read/write at r3: old value before the edge, new after.
    ra1 = 5'd3; we = 1'b1; wa = 5'd3; wd = 32'h0000_0002;
    #1;
    chk("rw before edge", rd1, 32'h1);
    edge_step();
    we = 1'b0;
    chk("rw after edge", rd1, 32'h2);

    // All three ports on the same address.
    ra1 = 5'd10; ra2 = 5'd10; dbg_a = 5'd10;
    #1;
    chk("tri rd1", rd1, 32'h55);
    chk("tri rd2", rd2, 32'h55);
    chk("tri dbg", dbg_d, 32'h55);

    // Mid-run reset with a write pending, then writes resume.
    rst_n = 1'b0; we = 1'b1; wa = 5'd10; wd = 32'h0000_0123;
    edge_step();
    rst_n = 1'b1; we = 1'b0;
    dbg_a = 5'd10; #1; chk("midrst r10", dbg_d, 32'h0);
    dbg_a = 5'd29; #1; chk("midrst r29", dbg_d, SPR);
    dbg_a = 5'd31; #1; chk("midrst r31", dbg_d, 32'h0);
    dbg_a = 5'd3;  #1; chk("midrst r3", dbg_d, 32'h0);
    we = 1'b1; wa = 5'd10; wd = 32'h0000_0077;
    edge_step();
    we = 1'b0;
    chk("resume rd1 r10", rd1, 32'h77);
    dbg_a = 5'd10; #1; chk("resume dbg r10", dbg_d, 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile32.md
# regfile32

General-purpose register file for the single-cycle CPU: 32 registers × 32 bits, two asynchronous read ports and one synchronous write port. It sits directly downstream of the write-back select mux (ALU result vs. memory load data). That mux output drives `wd`. Read data feeds the ALU operand muxes and store-data path. Register 0 is hardwired to zero, and register 29 (stack pointer) has a parameterised reset value.

## Interface
Parameters:
- `DATA_W`, 32: register width.
- `ADDR_W`, 5: register index width (2^ADDR_W registers).
- `SP_RESET`, 32'h0000_0000: value loaded into register 29 on reset.

Ports:
- `clk`, in, 1: single clock; all state updates on rising edge.
- `rst_n`, in, 1: synchronous, active-low reset, sampled on rising edge of `clk`.
- `ra1`, in, ADDR_W: read address, port 1 (rs field).
- `ra2`, in, ADDR_W: read address, port 2 (rt field).
- `rd1`, out, DATA_W: read data, port 1.
- `rd2`, out, DATA_W: read data, port 2.
- `we`, in, 1: write enable from control unit.
- `wa`, in, ADDR_W: write address (rd/rt after dest-select mux).
- `wd`, in, DATA_W: write data from write-back mux.
- `dbg_a`, in, ADDR_W: debug/testbench read address.
- `dbg_d`, out, DATA_W: debug read data.

## Operation
- Storage: registers 1..31 are flops. Register 0 has no storage, and reading it always returns 0.
- Reads: `rd1`, `rd2` and `dbg_d` are purely combinational from current register contents; address 0 returns 0.
- No write-to-read bypass. A read at the same address as a same-cycle write returns the old value until the edge. Bypass is forbidden because it would close a combinational loop through the ALU and write-back mux in the single-cycle datapath.
- Write: on rising edge with `rst_n`=1, `we`=1 and `wa`≠0, register[`wa`] ← `wd`. The following are no-ops: `we`=1 with `wa`=0, and `we`=0.
- Reset: on rising edge with `rst_n`=0:
  - all registers 1..31 ← 0, except register 29 ← `SP_RESET`;
  - any concurrent write is discarded (reset has priority);
  - reset asserted mid-program wipes state at that edge only, and writes resume on the first edge with `rst_n`=1.
- Before the first reset edge, contents are undefined (X in simulation). Outputs are not valid until reset has been applied.
- Read data is always the unsigned/raw bit pattern, with no width conversion. `wd` is stored verbatim.

## Timing
- Read latency: 0 cycles (combinational, address → data).
- Write latency: 1 edge. Data written at edge N is visible on read ports immediately after edge N.
- Output values after reset edge: `rd1`/`rd2`/`dbg_d` = 0 for any address except 29, which reads `SP_RESET`.
- The critical path is the read mux (32:1 × 32 bits). The write path is a decoder plus enable only.
- Two writes cannot collide (single write port). Simultaneous reads of the same address on all three ports are legal and return identical data.

## Structure
- Shared package `cpu_defs`:
  - `REG_W`=32, `REG_ADDR_W`=5;
  - named register indices `REG_ZERO`=0, `REG_SP`=29, `REG_RA`=31.
  - The control unit and dest-select mux use these same constants.
- No sub-module. The array, write decoder and three read muxes live inline; read-port logic is one function reused three times.

## Test plan
- Reset: hold `rst_n`=0 for one edge with `we`=1, `wa`=5, `wd`=32'hDEAD_BEEF, `SP_RESET`=32'h0000_3FFC. Required: `dbg_d` reads 0 for all addresses except 29, which reads 32'h0000_3FFC. Register 5 reads 0.
- Write/read: write 32'h1234_5678 to r8, then 32'hFFFF_FFFF to r31 on the next edge. Required: `ra1`=8 gives `rd1`=32'h1234_5678, and `ra2`=31 gives `rd2`=32'hFFFF_FFFF.
- Zero register: `we`=1, `wa`=0, `wd`=32'hAAAA_AAAA for one edge. Required: `rd1`/`rd2`/`dbg_d` at address 0 read 0. No other register changes (check all 31 via `dbg_a` sweep).
- Same-cycle read/write: r3=32'h0000_0001, then drive `ra1`=3 with `we`=1, `wa`=3, `wd`=32'h0000_0002. Required: `rd1`=32'h0000_0001 before the edge and 32'h0000_0002 after it.
- Write disabled and mid-run reset:
  - r10=32'h55; drive `we`=0, `wa`=10, `wd`=32'h99 for one edge. Required: r10 still reads 32'h55.
  - Assert `rst_n`=0 for one edge. Required: r10 reads 0 and r29 reads `SP_RESET`.
  - Write 32'h77 to r10 on the next edge. Required: r10 reads 32'h77.
